// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// PipeStageReg: two-entry elastic pipeline register (main + skid).
//
// Sits between an upstream producer and a downstream consumer using a
// valid/ready handshake. Every output (in_ready, out_valid, out_data) comes
// straight from flops, so neither side sees a combinational path through the
// stage. The skid entry absorbs the one beat that upstream can still push in
// the cycle when downstream first stalls.
//
// Ports
//   clk        in   1          single rising-edge clock
//   reset      in   1          asynchronous active-high reset
//   flush      in   1          synchronous kill of all held entries
//   in_valid   in   1          upstream offers in_data
//   in_data    in   WIDTH      upstream payload
//   in_ready   out  1          stage can accept this cycle (registered)
//   out_valid  out  1          out_data holds a live entry (registered)
//   out_data   out  WIDTH      downstream payload (registered)
//   out_ready  in   1          downstream accepts this cycle
//   cnt_clr    in   1          synchronous clear of stall_cnt
//   stall_cnt  out  CNT_WIDTH  saturating count of back-pressured cycles
//
// Parameters
//   WIDTH        payload width, 1..256
//   CNT_WIDTH    stall counter width, 1..32
//   RESET_VALUE  value loaded into both payload registers at reset
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int unsigned           WIDTH       = 32,
  parameter int unsigned           CNT_WIDTH   = 16,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  // Occupancy of the stage: nothing held, main only, or main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     main_q, main_d;
  logic [WIDTH-1:0]     skid_q, skid_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;

  logic accept;
  logic fire;
  logic stalled;

  // Handshakes are masked by flush so that a flushed cycle neither consumes
  // the upstream beat nor retires the downstream one.
  always_comb begin
    accept  = in_valid & in_ready & ~flush;
    fire    = out_valid & out_ready & ~flush;
    stalled = out_valid & ~out_ready & ~flush;
  end

  // State register. Reset empties the stage and restores the payload
  // registers and the stall counter to their idle values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  // Next-state logic. Flush overrides every handshake and always lands in
  // EMPTY; FULL never sees an accept because in_ready is low there.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) state_d = BUSY;
      end
      BUSY: begin
        if (accept && !fire)      state_d = FULL;
        else if (!accept && fire) state_d = EMPTY;
      end
      FULL: begin
        if (fire) state_d = BUSY;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  // Payload next-state. Main only takes new data when it is (or is about to
  // become) the head of the queue; skid only catches the beat that arrives
  // while main is stalled. Flush masks accept/fire, so it loads nothing and
  // out_data keeps whatever it last showed.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) main_d = in_data;
      end
      BUSY: begin
        if (accept && fire)       main_d = in_data;
        else if (accept && !fire) skid_d = in_data;
      end
      FULL: begin
        if (fire) main_d = skid_q;
      end
      default: begin
        main_d = main_q;
        skid_d = skid_q;
      end
    endcase
  end

  // Stall counter: counts cycles where the head entry is offered but refused.
  // It saturates rather than wraps, and a clear wins over a same-cycle count.
  always_comb begin
    stall_d = stall_q;
    if (cnt_clr)                          stall_d = '0;
    else if (stalled && stall_q != CNT_MAX) stall_d = stall_q + CNT_WIDTH'(1);
  end

  // Output decode. These depend only on flops, so the handshake outputs carry
  // no combinational path from the inputs.
  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
    out_data  = main_q;
    stall_cnt = stall_q;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits, legal range 1..256.
REQ-002 Parameter CNT_WIDTH, default 16: stall counter width in bits, legal range 1..32.
REQ-003 Parameter RESET_VALUE, default 0: WIDTH-bit value loaded into the payload registers at reset.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous kill of all held entries.
REQ-007 in_valid  input  1  upstream offers in_data.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 in_ready  output  1  stage can accept this cycle; registered output.
REQ-010 out_valid  output  1  out_data holds a live entry; registered output.
REQ-011 out_data  output  WIDTH  downstream payload; registered output.
REQ-012 out_ready  input  1  downstream accepts this cycle.
REQ-013 cnt_clr  input  1  synchronous clear of stall_cnt.
REQ-014 stall_cnt  output  CNT_WIDTH  count of back-pressured cycles.

Function
REQ-015 Accept = in_valid & in_ready & !flush; fire = out_valid & out_ready & !flush.
REQ-016 Storage: main register (drives out_data) and one skid register; state EMPTY (0 entries), BUSY (main valid), FULL (main and skid valid).
REQ-017 in_ready = 1 in EMPTY and BUSY, 0 in FULL; out_valid = 1 in BUSY and FULL.
REQ-018 EMPTY: accept -> BUSY, main <= in_data; otherwise stay.
REQ-019 BUSY: accept & fire -> BUSY, main <= in_data; accept & !fire -> FULL, skid <= in_data; !accept & fire -> EMPTY; neither -> hold.
REQ-020 FULL: fire -> BUSY, main <= skid; otherwise hold; no accept is possible (in_ready = 0).
REQ-021 Latency: data accepted at edge N is visible on out_data with out_valid = 1 after edge N; sustained throughput 1 entry/cycle when out_ready held 1.
REQ-022 Ordering: entries leave in acceptance order; no entry is duplicated or dropped except by flush.
REQ-023 While out_valid = 1 and out_ready = 0, out_data SHALL stay stable.
REQ-024 flush has priority over all handshakes: next state EMPTY, both entries invalidated, in_data offered that cycle dropped, out_data holding its value.
REQ-025 stall_cnt increments by 1 on each edge where out_valid = 1, out_ready = 0 and flush = 0.
REQ-026 stall_cnt saturates at 2^CNT_WIDTH-1 and never wraps.
REQ-027 cnt_clr sets stall_cnt to 0 and overrides a same-cycle increment; flush does not affect stall_cnt.
REQ-028 Payload registers load only on the transitions listed; no other update.

Reset
REQ-029 reset = 1 asynchronously forces: state EMPTY, out_valid 0, in_ready 1, out_data and skid RESET_VALUE, stall_cnt 0.
REQ-030 Reset asserted mid-transfer discards all entries; the first accept after deassertion behaves as from EMPTY.
REQ-031 Reset deassertion takes effect at the next clk edge; no handshake completes on that edge's preceding cycle while reset = 1.

Verification
REQ-032 Streaming: WIDTH=32, out_ready=1, in_valid=1 with 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on the following consecutive cycles, in_ready stays 1.
REQ-033 Back-pressure: out_ready=0, push 0xA then 0xB -> state FULL, in_ready=0, out_data=0xA stable; raise out_ready -> 0xA then 0xB delivered, in_ready returns to 1 one cycle after the first fire.
REQ-034 Flush: FULL holding 0xA,0xB, assert flush with in_valid=1 in_data=0xC -> next cycle out_valid=0, in_ready=1, 0xC never appears.
REQ-035 Counter: CNT_WIDTH=2, hold out_valid=1 out_ready=0 for 5 cycles -> stall_cnt 1,2,3,3,3; cnt_clr pulse -> 0.
REQ-036 Async reset: assert reset between edges while FULL -> out_valid=0, in_ready=1, out_data=RESET_VALUE immediately, without waiting for clk.
REQ-037 Random: random in_valid/out_ready/flush over 10000 cycles against a scoreboard queue -> order preserved, no loss except flushed entries, stable out_data under stall.
